// File: rtl/bmp_pkg.sv
// bmp_pkg: shared BMP constants, mode encoding, FSM state type and mode check.
//   BMP_MAGIC      "BM" as a little-endian 16-bit value (byte 0 = 8'h42, byte 1 = 8'h4D)
//   BMP_HDR_BYTES  default header length in bytes
//   BMP_FSIZE_LSB  byte offset of the 32-bit file_size field
package bmp_pkg;
    localparam logic [15:0] BMP_MAGIC = 16'h4D42;
    localparam int BMP_HDR_BYTES = 56;
    localparam int BMP_FSIZE_LSB = 2;
    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_TH   = 2'b01,
        MODE_PROC = 2'b10,
        MODE_BAD  = 2'b11
    } mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;
    function automatic logic mode_ok(input logic [1:0] m);
        return m == MODE_TH || m == MODE_PROC;
    endfunction
endpackage

// File: rtl/bmp_tx_skid.sv
// bmp_tx_skid: 2-entry register FIFO hiding the 1-cycle memory read latency.
//   clk, reset (sync, active-low), push/pop (same-cycle push+pop allowed),
//   flush (empties the FIFO), din/dout (dout = head entry), full, empty, count.
module bmp_tx_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] m1;
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;
    always_ff @(posedge clk) begin
        if (!reset || flush) count <= '0;
        else count <= count + 2'(push) - 2'(pop);
    end
    // Head refills from the second entry when full, otherwise straight from din.
    always_ff @(posedge clk) begin
        if ((push && empty) || (pop && (full || push))) dout <= full ? m1 : din;
        if (push && ((count == 2'd1 && !pop) || (full && pop))) m1 <= din;
    end
endmodule

// File: rtl/bmp_slave_tx.sv
// bmp_slave_tx: streams a BMP file from a synchronous-read memory to one scheduler slave port.
//   clk, reset (sync, active-low); start/cfg_mode/cfg_data_proc: launch and latched config;
//   mem_rd/mem_addr/mem_rdata: word fetch, data one cycle after mem_rd;
//   slv_mode/slv_data_valid/slv_data/slv_data_proc/slv_ready: stream port with back-pressure;
//   mstr_cmplt: scheduler end-of-image; busy/done/err: status (err held until next start).
module bmp_slave_tx
    import bmp_pkg::*;
#(
    parameter int DATA_BUS_SIZE = 32,
    parameter int HDR_BYTES     = BMP_HDR_BYTES,
    parameter int ADDR_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               cfg_mode,
    input  logic [7:0]               cfg_data_proc,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_BUS_SIZE-1:0] mem_rdata,
    output logic [1:0]               slv_mode,
    output logic                     slv_data_valid,
    output logic [DATA_BUS_SIZE-1:0] slv_data,
    output logic [7:0]               slv_data_proc,
    input  logic                     slv_ready,
    input  logic                     mstr_cmplt,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int BPW   = DATA_BUS_SIZE / 8;
    localparam int LG    = $clog2(BPW);
    localparam int HDR_W = HDR_BYTES / BPW;
    localparam int FS_W  = (BMP_FSIZE_LSB + 3) / BPW;
    localparam int CW    = ADDR_W + 1;
    state_t state;
    logic [1:0] mode_q, cnt;
    logic [7:0] proc_q;
    logic [CW-1:0] rd_cnt, acc_cnt, n_words, lim;
    logic [ADDR_W-1:0] ret_addr;
    logic [31:0] fs_q, w0_q, fsize;
    logic [15:0] magic;
    logic [32:0] nw33;
    logic [2:0] credit;
    logic [DATA_BUS_SIZE-1:0] head, head_m;
    logic rd_q, fs_ok, size_ok, hdr_eval, abort, push, fire, full, empty, last, valid;
    // On a 32-bit bus the size field straddles words 0 and 1, so word 0 is kept aside.
    if (BPW == 8) begin : g_w64
        assign magic = mem_rdata[15:0];
        assign fsize = mem_rdata[47:16];
    end else begin : g_w32
        assign magic = w0_q[15:0];
        assign fsize = {mem_rdata[15:0], w0_q[31:16]};
    end
    assign nw33     = (33'(fsize) + 33'(BPW - 1)) >> LG;
    assign size_ok  = fsize >= 32'(HDR_BYTES) && nw33 <= (33'(1) << ADDR_W);
    assign hdr_eval = state == ST_SEND && rd_q && ret_addr == ADDR_W'(FS_W);
    assign abort    = hdr_eval && !(magic == BMP_MAGIC && size_ok);
    assign push     = state == ST_SEND && rd_q;
    assign valid    = state == ST_SEND && fs_ok && !empty;
    assign fire     = valid && slv_ready;
    assign last     = acc_cnt == n_words - CW'(1);
    // A word popped this cycle frees its slot, which sustains one word per cycle.
    assign credit   = 3'(cnt) + 3'(rd_q) - 3'(fire);
    assign lim      = fs_ok ? n_words : CW'(HDR_W);
    assign mem_rd   = state == ST_SEND && rd_cnt < lim && credit < 3'd2 && (!full || fire);
    assign mem_addr = rd_cnt[ADDR_W-1:0];
    assign busy           = state != ST_IDLE;
    assign slv_mode       = mode_q;
    assign slv_data_proc  = proc_q;
    assign slv_data_valid = valid;
    assign slv_data       = valid ? head_m : '0;
    // Bytes past the end of the file are zeroed in the final word.
    always_comb begin
        head_m = head;
        for (int k = 0; k < BPW; k++)
            if (((33'(acc_cnt) << LG) + 33'(k)) >= 33'(fs_q)) head_m[8*k +: 8] = 8'h00;
    end
    bmp_tx_skid #(.W(DATA_BUS_SIZE)) u_skid (
        .clk(clk), .reset(reset), .push(push), .pop(fire), .flush(abort),
        .din(mem_rdata), .dout(head), .full(full), .empty(empty), .count(cnt)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mode_q   <= '0;
            proc_q   <= '0;
            rd_cnt   <= '0;
            acc_cnt  <= '0;
            n_words  <= '0;
            ret_addr <= '0;
            fs_q     <= '0;
            w0_q     <= '0;
            rd_q     <= 1'b0;
            fs_ok    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_q     <= mem_rd;
            ret_addr <= rd_cnt[ADDR_W-1:0];
            if (mem_rd) rd_cnt <= rd_cnt + 1'b1;
            if (push && ret_addr == '0) w0_q <= mem_rdata[31:0];
            case (state)
                ST_IDLE: if (start && !done) begin
                    if (mode_ok(cfg_mode)) begin
                        state   <= ST_SEND;
                        mode_q  <= cfg_mode;
                        proc_q  <= cfg_data_proc;
                        rd_cnt  <= '0;
                        acc_cnt <= '0;
                        fs_ok   <= 1'b0;
                        err     <= 1'b0;
                    end else begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                ST_SEND: if (abort) begin
                    state  <= ST_IDLE;
                    mode_q <= '0;
                    proc_q <= '0;
                    done   <= 1'b1;
                    err    <= 1'b1;
                end else begin
                    if (hdr_eval) begin
                        fs_ok   <= 1'b1;
                        fs_q    <= fsize;
                        n_words <= nw33[ADDR_W:0];
                    end
                    if (fire) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (last) state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (mstr_cmplt) begin
                    state  <= ST_IDLE;
                    mode_q <= '0;
                    proc_q <= '0;
                    done   <= 1'b1;
                    err    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_slave_tx.sv
// tb_bmp_slave_tx: table-driven transfers plus a mid-transfer reset sequence for bmp_slave_tx.
module tb_bmp_slave_tx;
    localparam int DW = 32;
    localparam int AW = 16;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, slv_ready = 1'b0, mstr_cmplt = 1'b0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_data_proc = '0;
    logic mem_rd, slv_data_valid, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] slv_data;
    logic [1:0] slv_mode;
    logic [7:0] slv_data_proc;

    always #5 clk = ~clk;

    bmp_slave_tx #(.DATA_BUS_SIZE(DW), .HDR_BYTES(56), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_data_proc(cfg_data_proc),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .slv_mode(slv_mode), .slv_data_valid(slv_data_valid), .slv_data(slv_data),
        .slv_data_proc(slv_data_proc), .slv_ready(slv_ready), .mstr_cmplt(mstr_cmplt),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] magic;
        logic [31:0] fsize;
        bit          rnd;
        bit          poke;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    logic [7:0] img [0:1023];
    logic [DW-1:0] rx [$];
    logic [DW-1:0] pdata;
    int total = 0, bad = 0;
    int cyc = 0, st_cyc = -1, first_acc = -1, last_acc = -1, done_cnt = 0, stab_err = 0, max_addr = -1;
    bit vseen = 0, pstall = 0;

    function automatic logic [DW-1:0] rdw(input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = (a < 256) ? img[4*a+k] : 8'h00;
        return w;
    endfunction

    function automatic logic [DW-1:0] expw(input int j, input logic [31:0] fs);
        logic [DW-1:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = (longint'(4*j+k) < longint'(fs)) ? img[4*j+k] : 8'h00;
        return w;
    endfunction

    // Memory model and stream monitor.
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? rdw(int'(mem_addr)) : '0;
        if (reset) begin
            if (start && !busy && st_cyc < 0) st_cyc = cyc;
            if (mem_rd && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (slv_data_valid) vseen = 1'b1;
            if (pstall && (!slv_data_valid || slv_data !== pdata)) stab_err = stab_err + 1;
            pstall = slv_data_valid && !slv_ready;
            pdata = slv_data;
            if (slv_data_valid && slv_ready) begin
                rx.push_back(slv_data);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (done) done_cnt = done_cnt + 1;
        end else pstall = 1'b0;
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic load_img(input logic [15:0] magic, input logic [31:0] fs);
        for (int i = 0; i < 1024; i++) img[i] = 8'(i * 7 + 3);
        img[0] = magic[7:0];
        img[1] = magic[15:8];
        for (int i = 0; i < 4; i++) img[2+i] = fs[8*i +: 8];
    endtask

    task automatic start_xfer(input logic [1:0] mode, input logic [7:0] proc);
        rx.delete();
        st_cyc = -1; first_acc = -1; last_acc = -1; done_cnt = 0; stab_err = 0; max_addr = -1; vseen = 1'b0;
        cfg_mode = mode;
        cfg_data_proc = proc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        bit got;
        bit bad_mode;
        logic [7:0] proc;
        proc = 8'hA5 ^ v.fsize[7:0];
        bad_mode = !(v.mode == 2'b01 || v.mode == 2'b10);
        load_img(v.magic, v.fsize);
        slv_ready = 1'b1;
        start_xfer(v.mode, proc);
        chk({tag, ".busy"}, busy, !bad_mode);
        chk({tag, ".mode"}, slv_mode, bad_mode ? 2'b00 : v.mode);
        chk({tag, ".proc"}, slv_data_proc, bad_mode ? 8'h00 : proc);
        got = done;
        for (int i = 0; i < 3000 && !got; i++) begin
            slv_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            mstr_cmplt = !v.exp_err && busy && !slv_data_valid && rx.size() == v.exp_words;
            if (v.poke && i == 4) begin
                start = 1'b1;
                cfg_mode = 2'b10;
                mstr_cmplt = 1'b1;
            end
            @(posedge clk); #1;
            mstr_cmplt = 1'b0;
            start = 1'b0;
            cfg_mode = v.mode;
            got = done;
        end
        chk({tag, ".done"}, got, 1);
        chk({tag, ".err"}, err, v.exp_err);
        @(posedge clk); #1;
        chk({tag, ".dcnt"}, done_cnt, 1);
        chk({tag, ".idle"}, {busy, done, slv_mode}, 0);
        chk({tag, ".words"}, rx.size(), v.exp_words);
        begin
            int mis = 0;
            for (int j = 0; j < rx.size(); j++) if (rx[j] !== expw(j, v.fsize)) mis++;
            chk({tag, ".data"}, mis, 0);
        end
        if (v.exp_err) chk({tag, ".noval"}, vseen, 0);
        else begin
            chk({tag, ".maxaddr"}, max_addr, v.exp_words - 1);
            chk({tag, ".stable"}, stab_err, 0);
        end
        if (!v.rnd && !v.exp_err) begin
            chk({tag, ".lat"}, first_acc - st_cyc, 4);
            chk({tag, ".span"}, last_acc - first_acc, v.exp_words - 1);
        end
    endtask

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{2'b01, 16'h4D42, 32'd64,     1'b0, 1'b0, 1'b0, 16};
        tbl[1]  = '{2'b10, 16'h4D42, 32'd62,     1'b0, 1'b0, 1'b0, 16};
        tbl[2]  = '{2'b01, 16'h4D42, 32'd200,    1'b1, 1'b0, 1'b0, 50};
        tbl[3]  = '{2'b01, 16'h4E42, 32'd64,     1'b0, 1'b0, 1'b1, 0};
        tbl[4]  = '{2'b10, 16'h4D42, 32'd40,     1'b0, 1'b0, 1'b1, 0};
        tbl[5]  = '{2'b11, 16'h4D42, 32'd64,     1'b0, 1'b0, 1'b1, 0};
        tbl[6]  = '{2'b00, 16'h4D42, 32'd64,     1'b0, 1'b0, 1'b1, 0};
        tbl[7]  = '{2'b01, 16'h4D42, 32'd56,     1'b0, 1'b0, 1'b0, 14};
        tbl[8]  = '{2'b10, 16'h4D42, 32'd57,     1'b0, 1'b0, 1'b0, 15};
        tbl[9]  = '{2'b01, 16'h4D42, 32'h40001,  1'b0, 1'b0, 1'b1, 0};
        tbl[10] = '{2'b01, 16'h4D42, 32'd64,     1'b0, 1'b1, 1'b0, 16};
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.outs", {busy, done, err, slv_data_valid, mem_rd, slv_mode, slv_data_proc}, 0);
        chk("rst.data", slv_data, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 11; n++) run_xfer(tbl[n], $sformatf("v%0d", n));
        // Reset in the middle of a 16-word transfer, then a clean restart.
        load_img(16'h4D42, 32'd64);
        slv_ready = 1'b1;
        start_xfer(2'b01, 8'h3C);
        for (int i = 0; i < 100 && rx.size() < 7; i++) begin
            @(posedge clk); #1;
        end
        chk("mid.reached", rx.size() >= 7, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid.outs", {busy, done, err, slv_data_valid, mem_rd, slv_mode, slv_data_proc}, 0);
        chk("mid.data", slv_data, 0);
        reset = 1'b1;
        begin
            int dseen = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (done || busy) dseen++;
            end
            chk("mid.nodone", dseen, 0);
        end
        run_xfer(tbl[0], "restart");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
